// File: rtl/mold_hdr_seq.sv
// MoldUDP64 header sequencer: gathers the 20-byte header over three beats,
// converts the numeric fields to native order and tracks per-session sequence continuity.
module mold_hdr_seq (
    input  logic        clk,
    input  logic        nreset,
    input  logic        valid_i,
    input  logic        start_i,
    input  logic        last_i,
    input  logic [63:0] data_i,
    output logic        hdr_v_o,
    output logic [79:0] sid_o,
    output logic [63:0] seq_o,
    output logic [15:0] cnt_o,
    output logic        gap_o,
    output logic        dup_o,
    output logic        eos_o,
    output logic        trunc_o
);

    typedef enum logic [1:0] {IDLE, H1, H2, PAY} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_cap0;
    logic        w_cap1;
    logic        w_hdr;
    logic        w_trunc;

    logic [63:0] r_sid_lo;
    logic [15:0] r_sid_hi;
    logic [47:0] r_seq_hi;
    logic [63:0] r_exp_seq;
    logic [79:0] r_exp_sid;
    logic        r_trk_v;

    logic [79:0] w_sid;
    logic [63:0] w_seq;
    logic [15:0] w_cnt;
    logic        w_track;
    logic        w_gap;
    logic        w_dup;
    logic        w_eos;
    logic [63:0] w_exp_nxt;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) r_state <= IDLE;
        else         r_state <= w_next;
    end

    // A start beat always restarts the header, whatever state we were in.
    always_comb begin
        w_next  = r_state;
        w_cap0  = 1'b0;
        w_cap1  = 1'b0;
        w_hdr   = 1'b0;
        w_trunc = 1'b0;
        if (valid_i) begin
            if (start_i) begin
                w_cap0  = 1'b1;
                w_trunc = last_i || (r_state == H1) || (r_state == H2);
                w_next  = last_i ? IDLE : H1;
            end else begin
                case (r_state)
                    IDLE: w_next = IDLE;
                    H1: begin
                        w_cap1 = 1'b1;
                        if (last_i) begin
                            w_trunc = 1'b1;
                            w_next  = IDLE;
                        end else begin
                            w_next  = H2;
                        end
                    end
                    H2: begin
                        w_hdr  = 1'b1;
                        w_next = last_i ? IDLE : PAY;
                    end
                    PAY:     w_next = last_i ? IDLE : PAY;
                    default: w_next = IDLE;
                endcase
            end
        end
    end

    assign w_sid     = {r_sid_hi, r_sid_lo};
    assign w_seq     = {r_seq_hi, data_i[7:0], data_i[15:8]};
    assign w_cnt     = {data_i[23:16], data_i[31:24]};
    assign w_track   = r_trk_v && (w_sid == r_exp_sid);
    assign w_gap     = w_track && (w_seq > r_exp_seq);
    assign w_dup     = w_track && (w_seq < r_exp_seq);
    assign w_eos     = (w_cnt == 16'hFFFF);
    assign w_exp_nxt = w_eos ? w_seq : (w_seq + {48'd0, w_cnt});

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_sid_lo  <= '0;
            r_sid_hi  <= '0;
            r_seq_hi  <= '0;
            r_exp_seq <= '0;
            r_exp_sid <= '0;
            r_trk_v   <= 1'b0;
            hdr_v_o   <= 1'b0;
            sid_o     <= '0;
            seq_o     <= '0;
            cnt_o     <= '0;
            gap_o     <= 1'b0;
            dup_o     <= 1'b0;
            eos_o     <= 1'b0;
            trunc_o   <= 1'b0;
        end else begin
            hdr_v_o <= w_hdr;
            trunc_o <= w_trunc;
            if (w_cap0) r_sid_lo <= data_i;
            // Beat 1 carries sid bytes 8-9 then the six most significant sequence bytes.
            if (w_cap1) begin
                r_sid_hi <= data_i[15:0];
                r_seq_hi <= {data_i[23:16], data_i[31:24], data_i[39:32],
                             data_i[47:40], data_i[55:48], data_i[63:56]};
            end
            if (w_hdr) begin
                sid_o     <= w_sid;
                seq_o     <= w_seq;
                cnt_o     <= w_cnt;
                gap_o     <= w_gap;
                dup_o     <= w_dup;
                eos_o     <= w_eos;
                r_exp_sid <= w_sid;
                r_exp_seq <= w_exp_nxt;
                r_trk_v   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mold_hdr_seq.sv
// Scoreboard bench for mold_hdr_seq: directed packets push expected header/trunc
// events with their due cycle; a monitor pops and compares on every output pulse.
module tb_mold_hdr_seq;

    logic        clk = 1'b0;
    logic        nreset;
    logic        valid_i, start_i, last_i;
    logic [63:0] data_i;
    logic        hdr_v_o;
    logic [79:0] sid_o;
    logic [63:0] seq_o;
    logic [15:0] cnt_o;
    logic        gap_o, dup_o, eos_o, trunc_o;

    mold_hdr_seq dut (
        .clk(clk), .nreset(nreset), .valid_i(valid_i), .start_i(start_i),
        .last_i(last_i), .data_i(data_i), .hdr_v_o(hdr_v_o), .sid_o(sid_o),
        .seq_o(seq_o), .cnt_o(cnt_o), .gap_o(gap_o), .dup_o(dup_o),
        .eos_o(eos_o), .trunc_o(trunc_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          trunc;
        logic [79:0] sid;
        logic [63:0] seq;
        logic [15:0] cnt;
        logic        gap, dup, eos;
        int          due;
    } ev_t;

    ev_t exp_q[$];
    int  n_vec = 0;
    int  n_bad = 0;
    logic [79:0] sid1, sid2;

    function automatic logic [79:0] str2sid(input logic [79:0] s);
        logic [79:0] r;
        for (int k = 0; k < 10; k++) r[8*k +: 8] = s[8*(9-k) +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic l, input logic [63:0] d);
        @(negedge clk);
        valid_i = v; start_i = s; last_i = l; data_i = d;
    endtask

    task automatic build(input logic [79:0] sid, input logic [63:0] seq, input logic [15:0] cnt,
                         output logic [63:0] b0, output logic [63:0] b1, output logic [63:0] b2);
        logic [7:0]  w[24];
        logic [63:0] bb[3];
        for (int k = 0; k < 10; k++) w[k] = sid[8*k +: 8];
        for (int k = 0; k < 8; k++)  w[10+k] = seq[8*(7-k) +: 8];
        w[18] = cnt[15:8];
        w[19] = cnt[7:0];
        for (int k = 20; k < 24; k++) w[k] = 8'hAA;
        for (int b = 0; b < 3; b++)
            for (int k = 0; k < 8; k++) bb[b][8*k +: 8] = w[8*b + k];
        b0 = bb[0]; b1 = bb[1]; b2 = bb[2];
    endtask

    // npay > 0: payload beats with last on the final one; 0: last on beat 2; <0: left open in payload.
    task automatic send_beats(input logic [63:0] b0, input logic [63:0] b1, input logic [63:0] b2,
                              input int npay, input int stall, input bit trunc_b0,
                              input logic [79:0] sid, input logic [63:0] seq, input logic [15:0] cnt,
                              input logic g, input logic d, input logic e);
        ev_t ev;
        drive(1, 1, 0, b0);
        if (trunc_b0) begin
            ev = '{1'b1, '0, '0, '0, 1'b0, 1'b0, 1'b0, cyc + 1};
            exp_q.push_back(ev);
        end
        drive(1, 0, 0, b1);
        for (int i = 0; i < stall; i++) drive(0, 0, 0, 64'hDEAD_BEEF_0000_0000);
        drive(1, 0, (npay == 0), b2);
        ev = '{1'b0, sid, seq, cnt, g, d, e, cyc + 1};
        exp_q.push_back(ev);
        for (int i = 0; i < npay; i++) drive(1, 0, (i == npay - 1), 64'h5555_5555_5555_5555);
        drive(0, 0, 0, 64'd0);
    endtask

    task automatic send_pkt(input logic [79:0] sid, input logic [63:0] seq, input logic [15:0] cnt,
                            input int npay, input int stall, input bit trunc_b0,
                            input logic g, input logic d, input logic e);
        logic [63:0] b0, b1, b2;
        build(sid, seq, cnt, b0, b1, b2);
        send_beats(b0, b1, b2, npay, stall, trunc_b0, sid, seq, cnt, g, d, e);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {121'd0, hdr_v_o, gap_o, dup_o, eos_o, trunc_o, 2'b00}, 128'd0);
        chk({tag, "_sid"}, {48'd0, sid_o}, 128'd0);
        chk({tag, "_seqcnt"}, {48'd0, seq_o, cnt_o}, 128'd0);
    endtask

    task automatic monitor();
        ev_t e;
        bit  ok;
        forever begin
            @(negedge clk);
            if (nreset === 1'b1 && (hdr_v_o || trunc_o)) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_out: hdr_v=%0b trunc=%0b cyc=%0d", hdr_v_o, trunc_o, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.trunc)
                        ok = trunc_o && !hdr_v_o && (cyc == e.due);
                    else
                        ok = hdr_v_o && !trunc_o && (cyc == e.due) && (sid_o == e.sid) &&
                             (seq_o == e.seq) && (cnt_o == e.cnt) && (gap_o == e.gap) &&
                             (dup_o == e.dup) && (eos_o == e.eos);
                    if (!ok) begin
                        n_bad++;
                        $display("FAIL %s: got cyc=%0d hv=%0b tr=%0b sid=%h seq=%h cnt=%h g/d/e=%0b%0b%0b, want cyc=%0d sid=%h seq=%h cnt=%h g/d/e=%0b%0b%0b",
                                 e.trunc ? "trunc_evt" : "hdr_evt", cyc, hdr_v_o, trunc_o, sid_o, seq_o,
                                 cnt_o, gap_o, dup_o, eos_o, e.due, e.sid, e.seq, e.cnt, e.gap, e.dup, e.eos);
                    end
                end
            end
        end
    endtask

    initial begin
        logic [63:0] b0, b1, b2;
        sid1 = str2sid("SESSION001");
        sid2 = str2sid("SESSION002");
        nreset = 1'b0; valid_i = 0; start_i = 0; last_i = 0; data_i = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        nreset = 1'b1;

        fork
            monitor();
        join_none

        // Basic sequencing within SESSION001
        send_pkt(sid1, 64'd5,  16'd3, 1, 0, 0, 0, 0, 0);   // exp -> 8
        send_pkt(sid1, 64'd8,  16'd0, 0, 0, 0, 0, 0, 0);   // heartbeat on beat 2, exp 8
        send_pkt(sid1, 64'd6,  16'd1, 2, 0, 0, 0, 1, 0);   // dup, exp -> 7
        send_pkt(sid1, 64'd7,  16'd1, 1, 0, 0, 0, 0, 0);   // exp -> 8
        send_pkt(sid1, 64'd10, 16'd2, 1, 0, 0, 1, 0, 0);   // gap, exp -> 12
        send_pkt(sid2, 64'd100, 16'd5, 1, 0, 0, 0, 0, 0);  // new session, exp -> 105

        // Hand-built wire beats: seq bytes 01..08, count bytes 12 34
        build(sid2, 64'd0, 16'd0, b0, b1, b2);
        b1 = {8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, sid2[79:64]};
        b2 = {32'hAAAA_AAAA, 8'h34, 8'h12, 8'h08, 8'h07};
        send_beats(b0, b1, b2, 1, 0, 0, sid2, 64'h0102_0304_0506_0708, 16'h1234, 1, 0, 0);

        send_pkt(sid2, 64'h0102_0304_0506_193C, 16'hFFFF, 1, 0, 0, 0, 0, 1);  // eos, exp held
        send_pkt(sid2, 64'h0102_0304_0506_193C, 16'd1, 1, 0, 0, 0, 0, 0);      // exp -> ..193D
        send_pkt(sid2, 64'hFFFF_FFFF_FFFF_FFFE, 16'd3, 1, 0, 0, 1, 0, 0);      // gap, exp wraps to 1
        send_pkt(sid2, 64'd1, 16'd0, 0, 0, 0, 0, 0, 0);

        // Non-start beat in IDLE is ignored
        drive(1, 0, 1, 64'h1234_5678_9ABC_DEF0);
        drive(0, 0, 0, 64'd0);

        // last on beat 1 truncates
        build(sid2, 64'd1, 16'd1, b0, b1, b2);
        drive(1, 1, 0, b0);
        drive(1, 0, 1, b1);
        exp_q.push_back('{1'b1, '0, '0, '0, 1'b0, 1'b0, 1'b0, cyc + 1});
        drive(0, 0, 0, 64'd0);

        // start while in H2 truncates, the restarted packet parses normally
        drive(1, 1, 0, b0);
        drive(1, 0, 0, b1);
        send_pkt(sid2, 64'd1, 16'd2, 1, 0, 1, 0, 0, 0);    // exp -> 3

        // 3-cycle stall before beat 2, packet left open in payload
        send_pkt(sid2, 64'd3, 16'd0, -1, 3, 0, 0, 0, 0);

        // start in payload: no trunc; reset lands while in H2
        build(sid2, 64'd77, 16'd1, b0, b1, b2);
        drive(1, 1, 0, b0);
        drive(1, 0, 0, b1);
        @(posedge clk);
        #2;
        nreset = 1'b0;
        valid_i = 0; start_i = 0; last_i = 0;
        #1;
        chk_zero("mid_reset");
        @(negedge clk);
        nreset = 1'b1;
        drive(0, 0, 0, 64'd0);
        drive(0, 0, 0, 64'd0);
        send_pkt(sid2, 64'd50, 16'd1, 1, 0, 0, 0, 0, 0);   // tracking cleared: no flags

        repeat (5) drive(0, 0, 0, 64'd0);
        chk("pending_events", 128'(exp_q.size()), 128'd0);
        disable fork;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got cyc=%0d, want finish", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mold_hdr_seq.md
# mold_hdr_seq

Header sequencer for the MoldUDP64 receive path. Consumes the 64-bit beat stream of a packet, collects the 20-byte MoldUDP64 header across three beats, byte-swaps the big-endian numeric fields into little-endian values, and tracks the expected sequence number per session to flag gaps, duplicates and end-of-session. It sits between the UDP payload stream and the message splitter, and it owns the header's endianness conversion.

## Interface
- No parameters; widths are fixed by the MoldUDP64 header format.
- clk  in  1  clock
- nreset  in  1  asynchronous active-low reset
- valid_i  in  1  beat valid; low = stall, no state change
- start_i  in  1  first beat of packet; qualified by valid_i
- last_i  in  1  final beat of packet; qualified by valid_i
- data_i  in  64  beat data; wire byte k of the beat on data_i[8k+7:8k]
- hdr_v_o  out  1  one-cycle pulse: header outputs valid
- sid_o  out  80  session id, raw wire order (wire byte k on [8k+7:8k])
- seq_o  out  64  sequence number, numeric value
- cnt_o  out  16  message count, numeric value
- gap_o  out  1  with hdr_v_o: seq_o > expected
- dup_o  out  1  with hdr_v_o: seq_o < expected
- eos_o  out  1  with hdr_v_o: cnt_o == 16'hFFFF
- trunc_o  out  1  one-cycle pulse: packet aborted inside the header

## Operation
- Header layout (wire bytes): 0-9 session, 10-17 sequence (big-endian), 18-19 count (big-endian).
- Beat 0 = wire bytes 0-7, beat 1 = 8-15, beat 2 = 16-23. Bytes 20-23 of beat 2 and all later beats are payload and are ignored.
- Numeric swap: seq_o = {w10,w11,...,w17}, with w10 in [63:56]; cnt_o = {w18,w19}.
- FSM states: IDLE, H1, H2, PAY.
  - IDLE: valid_i & start_i -> capture session bytes 0-7 -> H1. If last_i is also set -> trunc_o, stay IDLE. valid_i & ~start_i -> ignore.
  - H1: valid_i -> capture session bytes 8-9 and seq bytes 10-15 -> H2. If last_i -> trunc_o, go IDLE.
  - H2: valid_i -> capture seq bytes 16-17 and count bytes 18-19, issue hdr_v_o. last_i -> IDLE, else PAY. A 20-byte heartbeat ending on beat 2 is legal.
  - PAY: valid_i & last_i -> IDLE.
- start_i in H1 or H2: pulse trunc_o, discard the partial header, and treat the beat as a new beat 0 (-> H1). start_i in PAY: treat as a new beat 0 (-> H1), with no trunc_o.
- Sequence tracking registers: exp_seq (64), exp_sid (80), trk_v (1).
  - If trk_v = 0 or sid differs from exp_sid: gap_o = dup_o = 0, and tracking reloads.
  - Otherwise: gap_o = seq > exp_seq and dup_o = seq < exp_seq, using unsigned 64-bit compares.
  - Update on every header: exp_sid <- sid, trk_v <- 1.
  - If cnt = FFFF: exp_seq <- seq (eos; no advance).
  - Else: exp_seq <- seq + cnt, with modulo 2^64 wrap and cnt zero-extended. cnt = 0 (heartbeat) leaves exp_seq = seq.
  - A duplicate still updates exp_seq by this rule.
- Header outputs hold their value until the next hdr_v_o.

## Timing
- hdr_v_o and all header and flag outputs are registered. They appear the cycle after beat 2 is accepted (1-cycle latency).
- trunc_o is registered and appears the cycle after the offending beat.
- Stalls (valid_i = 0) extend latency by the same number of cycles; no bubbles are added otherwise.
- The block is always ready; there is no backpressure.
- Reset (async assert, sync deassert at the source) clears all outputs to 0, sets state IDLE, trk_v = 0, exp_seq = 0, exp_sid = 0.
- Reset mid-header discards the partial header. No outputs pulse after release.

## Test plan
- Single packet: sid "SESSION001", seq 0x0000000000000005, cnt 3, three beats plus last. Required: hdr_v_o one cycle after beat 2, seq_o = 5, cnt_o = 3, gap_o = dup_o = 0. Next packet with seq 8: no flag. Next packet with seq 10: gap_o = 1.
- Duplicate: after the expected sequence becomes 8, send seq 6 cnt 1 -> dup_o = 1, and the next expected sequence = 7. Session change to "SESSION002" with seq 100 -> no gap or dup flags.
- Byte swap: seq bytes 01 02 ... 08 on the wire -> seq_o = 64'h0102030405060708. Count bytes 12 34 -> cnt_o = 16'h1234. Heartbeat cnt 0 ending on beat 2 with last_i -> hdr_v_o, state returns to IDLE.
- End of session: cnt FFFF -> eos_o = 1, and the expected sequence is unchanged. Wrap case: seq = FFFF_FFFF_FFFF_FFFE, cnt 3 -> next expected = 1.
- Truncation:
  - last_i on beat 1 -> trunc_o, no hdr_v_o.
  - start_i while in H2 -> trunc_o, and the new packet then parses normally.
  - valid_i low for 3 cycles between beats -> hdr_v_o delayed by 3 cycles.
- Reset asserted while in H2 -> all outputs 0 immediately. After release, the first packet's header shows no gap or dup.
